div_sequencer: RTL and testbench
================================

# div_sequencer

Iterative divide/remainder unit for the RV32M extension (DIV, DIVU, REM, REMU; funct3 4–7 of the R-type opcode with the M-extension funct7). It sits beside the integer execute stage and owns a single shared 32-bit restoring-division datapath. A small state machine sequences that datapath over a fixed number of cycles. It tells the pipeline to stall through `busy_o` and returns one registered result with a single-cycle `valid_o` pulse.

## Interface

Parameters:
- `DATA_SIZE`, default 32: operand and result width; the iteration count equals `DATA_SIZE`.

Ports:
- `clk`  in  1  clock; the single clock.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `start_i`  in  1  request a division; sampled on the rising edge.
- `func_i`  in  3  funct3: 4 = div, 5 = divu, 6 = rem, 7 = remu.
- `op_a_i`  in  DATA_SIZE  dividend (rs1).
- `op_b_i`  in  DATA_SIZE  divisor (rs2).
- `flush_i`  in  1  synchronous abort of any in-flight operation.
- `busy_o`  out  1  operation in progress; the pipeline must hold the execute stage.
- `valid_o`  out  1  one-cycle pulse: `result_o` is valid.
- `result_o`  out  DATA_SIZE  quotient or remainder; held until the next accepted start.

## Operation

States and transitions:
- IDLE → PREP on an accepted start.
- PREP → ITER.
- ITER → ITER while the 6-bit counter is below 31; at 31, go to FIN.
- FIN → IDLE and pulse `valid_o`.

Accepted start:
- An accepted start requires `start_i`=1, state IDLE, `func_i[2]`=1 and `flush_i`=0.
- The block captures `func_i`, `op_a_i` and `op_b_i` on that edge.
- Any other `start_i` is ignored, including a start while busy and a start with `func_i` 0–3.

PREP:
- Signed ops (4, 6): convert both operands to magnitude.
- Record `neg_q = a[31]^b[31]` and `neg_r = a[31]`.
- Unsigned ops: use the operands unchanged; both negate flags are 0.

ITER, restoring division, one bit per cycle:
- `{rem, quo}` is shifted left by 1.
- Trial value `rem − divisor`, computed DATA_SIZE+1 bits wide.
- If the trial is non-negative, `rem` takes the trial and `quo[0]` is set to 1; otherwise `rem` is kept and `quo[0]` is 0.

FIN:
- Apply the sign correction: negate the quotient if `neg_q`, the remainder if `neg_r`.
- Select the quotient (funct3 4/5) or the remainder (6/7) and register it into `result_o`.

Special cases (RISC-V mandated). Latency stays fixed; only FIN's selection is overridden.
- Divisor 0: div/divu return 0xFFFFFFFF; rem/remu return the dividend unchanged.
- Signed overflow (0x80000000 / 0xFFFFFFFF): div returns 0x80000000; rem returns 0.

Flush:
- `flush_i`=1 in any state → IDLE on the next edge.
- `busy_o` drops, no `valid_o` pulse is produced, and `result_o` keeps its previous value.
- Flush takes priority over `start_i` and over FIN completion; a flush in FIN suppresses the pulse.

Reset:
- `rst_n` low forces IDLE immediately and asynchronously, including mid-operation.
- Reset values: `busy_o`=0, `valid_o`=0, `result_o`=0, counter 0, internal registers 0.

## Timing

- Start accepted at edge k. `busy_o` is high after edge k, through the cycle ending at edge k+34.
- `valid_o`=1 for exactly the one cycle following edge k+34, with `busy_o`=0 in that cycle.
- Fixed latency of 34 cycles, start edge to result edge, for every operand value.
- A new start may be accepted in the same cycle `valid_o` is high (back-to-back operation); the next result follows at +34.
- `busy_o` and `valid_o` are decoded from registered state; there are no combinational paths from inputs to outputs.

## Test plan

- Unsigned: divu 100/7 → `result_o`=14, `valid_o` exactly 34 cycles after the start edge. Then remu 100/7 → 2.
- Signed: div −7/2 → 0xFFFFFFFD. rem −7/2 → 0xFFFFFFFF. rem 7/−2 → 1.
- Special cases:
  - divu 5/0 → 0xFFFFFFFF.
  - remu 5/0 → 5.
  - div 0x80000000/0xFFFFFFFF → 0x80000000.
  - rem of the same operands → 0.
- Handshake:
  - A start during busy with different operands is ignored; the original result arrives on time.
  - A start with funct3=0 in IDLE produces no busy.
  - A back-to-back start in the `valid_o` cycle completes correctly.
- Flush at iteration 10 → `busy_o`=0 on the next cycle, no `valid_o`, `result_o` unchanged. A following divu 9/3 returns 3 after 34 cycles.
- Asynchronous reset asserted mid-ITER (not clock-aligned) → all outputs 0 immediately. After release, divu 0xFFFFFFFF/1 returns 0xFFFFFFFF.

Source files
------------

// File: rtl/div_sequencer.sv
// Iterative RV32M divide/remainder unit: one shared restoring-division datapath, one quotient bit per cycle.
// Fixed 34-cycle latency from the start edge to the result edge; busy_o holds the pipeline, and new starts are ignored while busy.
module div_sequencer #(
  parameter int DATA_SIZE = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [2:0]           func_i,
  input  logic [DATA_SIZE-1:0] op_a_i,
  input  logic [DATA_SIZE-1:0] op_b_i,
  input  logic                 flush_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [DATA_SIZE-1:0] result_o
);

  localparam int W = DATA_SIZE;
  localparam logic [5:0] LAST_ITER = 6'(W - 1);

  typedef enum logic [1:0] {IDLE, PREP, ITER, FIN} state_t;

  state_t         state;
  logic [1:0]     func_q;
  logic [W-1:0]   a_q, b_q;
  logic [W-1:0]   divisor, rem, quo;
  logic [W-1:0]   result_q;
  logic           neg_q, neg_r;
  logic           valid_q;
  logic [5:0]     cnt;

  logic           signed_op;
  logic [W-1:0]   a_mag, b_mag;
  logic [W:0]     rem_sh;
  logic [W+1:0]   trial;
  logic           trial_ok;
  logic [W-1:0]   quo_fix, rem_fix;
  logic           div_zero, ovf;
  logic [W-1:0]   fin_res;

  // funct3 4 and 6 are the signed variants; func_q holds funct3[1:0]
  assign signed_op = ~func_q[0];

  always_comb begin
    a_mag    = (signed_op && a_q[W-1]) ? -a_q : a_q;
    b_mag    = (signed_op && b_q[W-1]) ? -b_q : b_q;
    rem_sh   = {rem, quo[W-1]};
    trial    = {1'b0, rem_sh} - {2'b00, divisor};
    trial_ok = ~trial[W+1];
    quo_fix  = neg_q ? -quo : quo;
    rem_fix  = neg_r ? -rem : rem;
    div_zero = (b_q == '0);
    ovf      = signed_op && (a_q == {1'b1, {(W-1){1'b0}}}) && (b_q == '1);
    // Special cases only override the final selection, so latency never changes
    if (div_zero)
      fin_res = func_q[1] ? a_q : '1;
    else if (ovf)
      fin_res = func_q[1] ? '0 : a_q;
    else
      fin_res = func_q[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      func_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      result_q <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      valid_q  <= 1'b0;
      cnt      <= '0;
    end else if (flush_i) begin
      state   <= IDLE;
      cnt     <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && func_i[2]) begin
            func_q <= func_i[1:0];
            a_q    <= op_a_i;
            b_q    <= op_b_i;
            state  <= PREP;
          end
        end
        PREP: begin
          divisor <= b_mag;
          quo     <= a_mag;
          rem     <= '0;
          cnt     <= '0;
          neg_q   <= signed_op & (a_q[W-1] ^ b_q[W-1]);
          neg_r   <= signed_op & a_q[W-1];
          state   <= ITER;
        end
        ITER: begin
          rem <= trial_ok ? trial[W-1:0] : rem_sh[W-1:0];
          quo <= {quo[W-2:0], trial_ok};
          cnt <= cnt + 6'd1;
          if (cnt == LAST_ITER)
            state <= FIN;
        end
        FIN: begin
          result_q <= fin_res;
          valid_q  <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o   = (state != IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Randomized and directed bench for div_sequencer against an arithmetic RV32M reference model.
module tb_div_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [2:0]  func_i;
  logic [31:0] op_a_i;
  logic [31:0] op_b_i;
  logic        flush_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int          n_chk;
  int          n_pass;
  logic [31:0] last_res;

  div_sequencer #(.DATA_SIZE(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .func_i   (func_i),
    .op_a_i   (op_a_i),
    .op_b_i   (op_b_i),
    .flush_i  (flush_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask

  // RISC-V M-extension semantics, computed directly with language arithmetic
  function automatic logic [31:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    if (b == 0) return (f == 3'd6 || f == 3'd7) ? a : 32'hFFFF_FFFF;
    case (f)
      3'd4: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return a / b;
      3'd6: return (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'h0 : 32'(sa % sb);
      default: return a % b;
    endcase
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
    chk("idle_busy", {31'b0, busy_o}, 32'd0);
    chk("idle_valid", {31'b0, valid_o}, 32'd0);
  endtask

  // Called #1 after a rising edge; drives a start that is sampled on the next edge.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input int inject_at, input int flush_at);
    logic [31:0] exp;
    int got, bad_busy, spurious;
    exp = ref_div(f, a, b);
    start_i = 1'b1; func_i = f; op_a_i = a; op_b_i = b;
    @(posedge clk); #1;
    start_i = 1'b0; op_a_i = $urandom; op_b_i = $urandom; func_i = 3'($urandom);
    chk("busy_after_start", {31'b0, busy_o}, 32'd1);
    got = 0; bad_busy = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == inject_at) begin
        start_i = 1'b1; func_i = 3'd5; op_a_i = $urandom; op_b_i = 32'd1;
      end
      if (n == flush_at) flush_i = 1'b1;
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      if (n == flush_at) begin
        chk("flush_busy", {31'b0, busy_o}, 32'd0);
        chk("flush_valid", {31'b0, valid_o}, 32'd0);
        spurious = 0;
        repeat (40) begin
          @(posedge clk); #1;
          if (valid_o || busy_o) spurious++;
        end
        chk("flush_quiet", 32'(spurious), 32'd0);
        chk("flush_result_kept", result_o, last_res);
        return;
      end
      if (valid_o) begin
        got = n;
        break;
      end
      if (!busy_o) bad_busy++;
    end
    chk("latency", 32'(got), 32'd34);
    chk("busy_held", 32'(bad_busy), 32'd0);
    chk("busy_in_valid", {31'b0, busy_o}, 32'd0);
    chk($sformatf("result f%0d %h/%h", f, a, b), result_o, exp);
    last_res = exp;
  endtask

  initial begin
    logic [31:0] edge_vals [6];
    logic [31:0] a, b;
    logic [2:0]  f;
    n_chk = 0; n_pass = 0; last_res = 32'h0;
    edge_vals[0] = 32'h0;        edge_vals[1] = 32'h1;
    edge_vals[2] = 32'hFFFF_FFFF; edge_vals[3] = 32'h8000_0000;
    edge_vals[4] = 32'h7FFF_FFFF; edge_vals[5] = 32'hFFFF_FFFE;

    rst_n = 1'b0; start_i = 1'b0; func_i = 3'd0; op_a_i = 0; op_b_i = 0; flush_i = 1'b0;
    #12;
    chk("reset_busy", {31'b0, busy_o}, 32'd0);
    chk("reset_valid", {31'b0, valid_o}, 32'd0);
    chk("reset_result", result_o, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    do_op(3'd5, 32'd100, 32'd7, 0, 0);
    idle(2);
    do_op(3'd7, 32'd100, 32'd7, 0, 0);
    do_op(3'd4, -32'sd7, 32'd2, 0, 0);
    do_op(3'd6, -32'sd7, 32'd2, 0, 0);
    do_op(3'd6, 32'd7, -32'sd2, 0, 0);
    do_op(3'd5, 32'd5, 32'd0, 0, 0);
    do_op(3'd7, 32'd5, 32'd0, 0, 0);
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    do_op(3'd4, -32'sd9, 32'd0, 0, 0);
    idle(1);

    // Start while busy must be ignored
    do_op(3'd5, 32'd1000, 32'd10, 5, 0);
    idle(1);

    // funct3 below 4 is not a divide
    start_i = 1'b1; func_i = 3'd0; op_a_i = 32'd8; op_b_i = 32'd2;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk("non_div_no_busy", {31'b0, busy_o}, 32'd0);
    idle(1);

    // Back-to-back: second start issued in the valid cycle
    do_op(3'd4, 32'd1234567, -32'sd89, 0, 0);
    do_op(3'd6, 32'd1234567, -32'sd89, 0, 0);
    idle(1);

    // Flush while the counter is at 10
    do_op(3'd5, 32'd50, 32'd5, 0, 12);
    do_op(3'd5, 32'd9, 32'd3, 0, 0);
    idle(1);

    // Asynchronous reset in the middle of the iterations
    start_i = 1'b1; func_i = 3'd5; op_a_i = 32'd77; op_b_i = 32'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (15) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy_o}, 32'd0);
    chk("arst_valid", {31'b0, valid_o}, 32'd0);
    chk("arst_result", result_o, 32'd0);
    last_res = 32'h0;
    #20;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(3'd5, 32'hFFFF_FFFF, 32'd1, 0, 0);

    for (int i = 0; i < 24; i++) begin
      f = 3'(4 + $urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: begin a = $urandom; b = $urandom; end
        1: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 40); end
        2: begin a = edge_vals[$urandom_range(0, 5)]; b = edge_vals[$urandom_range(0, 5)]; end
        default: begin a = $urandom; b = 32'($signed(8'($urandom))); end
      endcase
      do_op(f, a, b, 0, 0);
      if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
